// File: rtl/cic_rate_controller.sv
// CIC decimation sequencing: applies ratio changes, clears the filter,
// then masks the settling outputs before releasing the stream downstream.
module cic_rate_controller #(
  parameter int STAGES             = 3,
  parameter int MAX_DECIM_LOG2     = 6,
  parameter int DEFAULT_DECIM_LOG2 = 3,
  parameter int CLEAR_CYCLES       = 2,
  parameter int SETTLE_EXTRA       = 0,
  localparam int DW = $clog2(MAX_DECIM_LOG2 + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_decim_log2,
  output logic          cfg_ready,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          cic_data_valid,
  output logic          cic_clear,
  output logic [DW-1:0] cic_decim_log2,
  input  logic          cic_out_valid,
  output logic          out_valid,
  output logic          settled,
  output logic [15:0]   drop_count
);

  localparam int SN = STAGES + SETTLE_EXTRA;
  localparam int SW = $clog2(SN + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_CLEAR,
    S_SETTLE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_decim;
  logic [CW-1:0]   r_clr_cnt;
  logic [SW-1:0]   r_settle_cnt;
  logic [15:0]     r_drop;
  logic            r_cfg_err;

  logic            w_in_ready;
  logic            w_cfg_ready;
  logic            w_clear;
  logic            w_settled;
  logic            w_pass;
  logic            w_count;
  logic            w_cfg_fire;
  logic            w_cfg_legal;
  logic            w_last_settle;
  logic            w_clr_done;
  logic            w_drop_sat;

  assign w_cfg_fire  = cfg_valid & w_cfg_ready;
  assign w_cfg_legal = (cfg_decim_log2 != '0) &&
                       (cfg_decim_log2 <= DW'(MAX_DECIM_LOG2));
  assign w_last_settle = (r_settle_cnt == SW'(SN - 1));
  assign w_clr_done    = (r_clr_cnt == CW'(1));
  assign w_drop_sat    = (r_drop == 16'hFFFF);

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b1;
    w_cfg_ready = 1'b0;
    w_clear     = 1'b0;
    w_settled   = 1'b0;
    w_pass      = 1'b0;
    w_count     = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_cfg_ready = 1'b1;
        w_settled   = 1'b1;
        w_pass      = 1'b1;
        if (cfg_valid && w_cfg_legal)
          w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_in_ready = 1'b0;
        w_clear    = 1'b1;
        if (w_clr_done)
          w_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_count = cic_out_valid;
        if (cic_out_valid && w_last_settle)
          w_next = S_RUN;
      end
      default: begin
        w_next = S_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SETTLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ratio and clear length are captured together on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decim   <= DW'(DEFAULT_DECIM_LOG2);
      r_clr_cnt <= '0;
    end else if (w_cfg_fire && w_cfg_legal) begin
      r_decim   <= cfg_decim_log2;
      r_clr_cnt <= CW'(CLEAR_CYCLES);
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_settle_cnt <= '0;
    end else if (w_count) begin
      r_settle_cnt <= r_settle_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_fire & ~w_cfg_legal;
      if (w_count && !w_drop_sat)
        r_drop <= r_drop + 16'd1;
    end
  end

  assign cfg_ready      = w_cfg_ready;
  assign cfg_err        = r_cfg_err;
  assign in_ready       = w_in_ready;
  assign cic_data_valid = in_valid & w_in_ready;
  assign cic_clear      = w_clear;
  assign cic_decim_log2 = r_decim;
  assign out_valid      = cic_out_valid & w_pass;
  assign settled        = w_settled;
  assign drop_count     = r_drop;

endmodule

// File: tb/tb_cic_rate_controller.sv
// Scoreboard bench for cic_rate_controller: default instance for the
// sequencing cases, long-settle instance for drop_count saturation.
module tb_cic_rate_controller;

  localparam int BN = 3 + 21843;

  typedef struct {
    bit ov;
    int drop;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic [2:0]  cfg_decim_log2;
  logic        cfg_ready;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic        cic_data_valid;
  logic        cic_clear;
  logic [2:0]  cic_decim_log2;
  logic        cic_out_valid;
  logic        out_valid;
  logic        settled;
  logic [15:0] drop_count;

  logic        b_rst_n;
  logic        b_cfg_valid;
  logic [2:0]  b_cfg_decim_log2;
  logic        b_cfg_ready;
  logic        b_cfg_err;
  logic        b_in_valid;
  logic        b_in_ready;
  logic        b_cic_data_valid;
  logic        b_cic_clear;
  logic [2:0]  b_cic_decim_log2;
  logic        b_cic_out_valid;
  logic        b_out_valid;
  logic        b_settled;
  logic [15:0] b_drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q[$];
  exp_t qb[$];
  int   eq[$];

  cic_rate_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_decim_log2 (cfg_decim_log2),
    .cfg_ready      (cfg_ready),
    .cfg_err        (cfg_err),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cic_data_valid (cic_data_valid),
    .cic_clear      (cic_clear),
    .cic_decim_log2 (cic_decim_log2),
    .cic_out_valid  (cic_out_valid),
    .out_valid      (out_valid),
    .settled        (settled),
    .drop_count     (drop_count)
  );

  cic_rate_controller #(.SETTLE_EXTRA(21843)) dut_b (
    .clk            (clk),
    .rst_n          (b_rst_n),
    .cfg_valid      (b_cfg_valid),
    .cfg_decim_log2 (b_cfg_decim_log2),
    .cfg_ready      (b_cfg_ready),
    .cfg_err        (b_cfg_err),
    .in_valid       (b_in_valid),
    .in_ready       (b_in_ready),
    .cic_data_valid (b_cic_data_valid),
    .cic_clear      (b_cic_clear),
    .cic_decim_log2 (b_cic_decim_log2),
    .cic_out_valid  (b_cic_out_valid),
    .out_valid      (b_out_valid),
    .settled        (b_settled),
    .drop_count     (b_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_a(input bit ov, input int drop);
    exp_t t;
    t.ov = ov;
    t.drop = drop;
    q.push_back(t);
  endtask

  task automatic push_b(input bit ov, input int drop);
    exp_t t;
    t.ov = ov;
    t.drop = drop;
    qb.push_back(t);
  endtask

  task automatic pulse(input bit ov, input int drop, input int gap);
    @(posedge clk); #1;
    push_a(ov, drop);
    cic_out_valid = 1'b1;
    @(posedge clk); #1;
    cic_out_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cic_out_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_out: got output with empty queue");
      end else begin
        e = q.pop_front();
        chk("a_out_valid", out_valid, e.ov);
        chk("a_drop_count", drop_count, e.drop);
      end
    end
    if (rst_n && cfg_err) begin
      if (eq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cfg_err_unexpected: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        chk("cfg_err_cycle", cyc, eq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rst_n && b_cic_out_valid) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_out: got output with empty queue");
      end else begin
        e = qb.pop_front();
        chk("b_out_valid", b_out_valid, e.ov);
        chk("b_drop_count", b_drop_count, e.drop);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nclr;
    int ill[2];
    int bd[6];
    ill = '{0, 7};
    bd  = '{6, 6, 6, 7, 8, 9};

    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_decim_log2 = '0;
    in_valid = 1'b0;
    cic_out_valid = 1'b0;
    b_rst_n = 1'b0;
    b_cfg_valid = 1'b0;
    b_cfg_decim_log2 = '0;
    b_in_valid = 1'b0;
    b_cic_out_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cic_clear", cic_clear, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_settled", settled, 0);
    chk("reset_decim", cic_decim_log2, 3);
    chk("reset_drop", drop_count, 0);
    chk("reset_cfg_err", cfg_err, 0);
    rst_n = 1'b1;

    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("data_valid_settle", cic_data_valid, 1);
    pulse(0, 0, 7);
    pulse(0, 1, 7);
    pulse(0, 2, 7);
    @(negedge clk);
    chk("settled_after_3", settled, 1);
    chk("drop_after_3", drop_count, 3);
    pulse(1, 3, 7);

    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_decim_log2 = 3'd5;
    @(negedge clk);
    chk("legal_cfg_ready", cfg_ready, 1);
    chk("legal_accept_data_valid", cic_data_valid, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    push_a(0, 3);
    cic_out_valid = 1'b1;
    chk("legal_decim", cic_decim_log2, 5);
    nclr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!cic_clear) break;
      nclr++;
      chk("clear_in_ready", in_ready, 0);
      chk("clear_decim", cic_decim_log2, 5);
      @(posedge clk); #1;
      cic_out_valid = 1'b0;
    end
    if (cic_out_valid) begin
      @(posedge clk); #1;
      cic_out_valid = 1'b0;
    end
    chk("clear_cycles", nclr, 2);
    chk("settle_in_ready", in_ready, 1);
    chk("settle_cfg_ready", cfg_ready, 0);
    pulse(0, 3, 2);
    pulse(0, 4, 2);
    pulse(0, 5, 2);
    @(negedge clk);
    chk("legal_settled", settled, 1);
    chk("legal_drop", drop_count, 6);
    pulse(1, 6, 2);

    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_decim_log2 = 3'(ill[k]);
      @(negedge clk);
      chk("ill_cfg_ready", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      eq.push_back(cyc);
      @(negedge clk);
      chk("ill_clear", cic_clear, 0);
      chk("ill_decim", cic_decim_log2, 5);
      chk("ill_settled", settled, 1);
      @(negedge clk);
      chk("ill_settled_2", settled, 1);
    end
    chk("cfg_err_all_seen", eq.size(), 0);

    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_decim_log2 = 3'd2;
    @(posedge clk); #1;
    cfg_decim_log2 = 3'd4;
    chk("b2b_decim_2", cic_decim_log2, 2);
    for (int k = 1; k <= 6; k++) begin
      push_a(k == 6, bd[k-1]);
      cic_out_valid = 1'b1;
      @(negedge clk);
      chk("b2b_cfg_ready", cfg_ready, (k == 6));
      chk("b2b_clear", cic_clear, (k <= 2));
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    cic_out_valid = 1'b0;
    chk("b2b_decim_4", cic_decim_log2, 4);
    @(negedge clk);
    chk("b2b_second_clear", cic_clear, 1);
    @(negedge clk);
    pulse(0, 9, 1);
    pulse(0, 10, 1);
    pulse(0, 11, 1);
    @(negedge clk);
    chk("b2b_settled", settled, 1);
    chk("b2b_drop", drop_count, 12);

    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_decim_log2 = 3'd6;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("mc_clear_before", cic_clear, 1);
    chk("mc_decim_before", cic_decim_log2, 6);
    rst_n = 1'b0;
    #1;
    chk("mc_clear_async", cic_clear, 0);
    chk("mc_decim_async", cic_decim_log2, 3);
    chk("mc_drop_async", drop_count, 0);
    chk("mc_in_ready_async", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mc_settled", settled, 0);
    chk("mc_cfg_ready", cfg_ready, 0);
    chk("mc_drop", drop_count, 0);
    pulse(0, 0, 2);
    pulse(0, 1, 2);
    pulse(0, 2, 2);
    pulse(1, 3, 2);
    in_valid = 1'b0;

    @(negedge clk);
    b_rst_n = 1'b1;
    chk("b_reset_decim", b_cic_decim_log2, 3);
    b_cfg_decim_log2 = 3'd4;
    b_cfg_valid = 1'b1;
    b_in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < BN; j++) begin
        @(posedge clk); #1;
        if (r == 2 && j == 0) b_cfg_valid = 1'b0;
        b_cic_out_valid = 1'b1;
        push_b(0, (r * BN + j > 65535) ? 65535 : r * BN + j);
      end
      @(posedge clk); #1;
      push_b(1, ((r + 1) * BN > 65535) ? 65535 : (r + 1) * BN);
      if (r < 2) begin
        repeat (2) begin
          @(posedge clk); #1;
          push_b(0, (r + 1) * BN);
        end
      end
    end
    @(posedge clk); #1;
    push_b(1, 65535);
    @(posedge clk); #1;
    b_cic_out_valid = 1'b0;
    @(negedge clk);
    chk("b_sat_drop", b_drop_count, 65535);
    chk("b_sat_settled", b_settled, 1);
    chk("b_sat_decim", b_cic_decim_log2, 4);
    chk("a_queue_drained", q.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
